// File: rtl/noc_parameters_pkg.sv
// Noc_parameters: shared NoC constants and types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default flit width, local channel count, arbiter state encoding,
// and a helper that sizes requester index fields.
package Noc_parameters;

  localparam int Noc_Data_Width = 32;
  localparam int NOC_NUM_CH     = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width that stays at least 1 bit for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_rr_lock_arbiter.sv
// noc_rr_lock_arbiter: per-channel round-robin arbiter that locks onto a packet owner.
// Latency: selection is combinational (0 cycles); state updates on the transfer edge.
// Backpressure: state only advances on xfer_i (valid & ready seen by the top).
// Ports:
//   noc_clk_i, noc_rst_i       clock, synchronous active-high reset
//   cand_i                     header candidates for this channel (IDLE arbitration)
//   owner_ok_i                 requesters currently targeting this channel
//   xfer_i, xfer_tail_i        a flit moved this cycle, and whether it was a tail
//   sel_vld_o, sel_idx_o       selected requester
//   pkt_cnt_o                  completed packet counter (wraps)
module noc_rr_lock_arbiter
  import Noc_parameters::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               noc_clk_i,
  input  logic               noc_rst_i,
  input  logic [NUM_REQ-1:0] cand_i,
  input  logic [NUM_REQ-1:0] owner_ok_i,
  input  logic               xfer_i,
  input  logic               xfer_tail_i,
  output logic               sel_vld_o,
  output logic [IDX_W-1:0]   sel_idx_o,
  output logic [CNT_W-1:0]   pkt_cnt_o
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] win_nxt;
  logic [IDX_W:0]   scan;

  // First candidate at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_REQ)) begin
        scan = scan - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_vld && cand_i[scan[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[IDX_W-1:0];
      end
    end
  end

  assign win_nxt = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);

  // While locked only the owner is selected; its channel match guards against
  // a requester ever being selected on both channels at once.
  always_comb begin
    if (state_q == ARB_LOCKED) begin
      sel_vld_o = owner_ok_i[owner_q];
      sel_idx_o = owner_q;
    end else begin
      sel_vld_o = win_vld;
      sel_idx_o = win_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        // Only headers can win in IDLE, so any transfer here starts a packet.
        if (xfer_i) begin
          ptr_d = win_nxt;
          if (xfer_tail_i) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = ARB_LOCKED;
            owner_d = win_idx;
          end
        end
      end
      ARB_LOCKED: begin
        if (xfer_i && xfer_tail_i) begin
          state_d = ARB_IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk_i) begin
    if (noc_rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pkt_cnt_o = cnt_q;

endmodule

// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: shares two router local injection channels among NUM_REQ requesters.
// Latency: 0 cycles, grant and flit mux are combinational; packets lock a channel header..tail.
// Backpressure: req_ready mirrors the selected channel's send_ready; VCready gates headers only.
// Ports:
//   noc_clk, noc_rst                       clock, synchronous active-high reset
//   req_valid/ready/flit/is_header/is_tail per-requester flit interface
//   req_vc_sel                             target channel per requester
//   chN_send_*                             router local channel N (N = 0, 1)
//   chN_pkt_cnt                            packets completed on channel N
module noc_inject_arbiter
  import Noc_parameters::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = Noc_Data_Width,
  parameter int CNT_W   = 16
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  input  logic [NUM_REQ-1:0]        req_vc_sel,
  output logic                      ch0_send_valid,
  input  logic                      ch0_send_ready,
  output logic [FLIT_W-1:0]         ch0_send_flit,
  input  logic                      ch0_send_VCready,
  output logic                      ch0_send_is_header,
  output logic                      ch0_send_is_tail,
  output logic [CNT_W-1:0]          ch0_pkt_cnt,
  output logic                      ch1_send_valid,
  input  logic                      ch1_send_ready,
  output logic [FLIT_W-1:0]         ch1_send_flit,
  input  logic                      ch1_send_VCready,
  output logic                      ch1_send_is_header,
  output logic                      ch1_send_is_tail,
  output logic [CNT_W-1:0]          ch1_pkt_cnt
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NOC_NUM_CH-1:0] ch_ready;
  logic [NOC_NUM_CH-1:0] ch_vcready;

  assign ch_ready   = {ch1_send_ready,   ch0_send_ready};
  assign ch_vcready = {ch1_send_VCready, ch0_send_VCready};

  for (genvar c = 0; c < NOC_NUM_CH; c++) begin : g_ch
    logic [NUM_REQ-1:0] on_ch;
    logic [NUM_REQ-1:0] cand;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;
    logic               xfer;
    logic               vld;
    logic               hdr;
    logic               tail;
    logic [FLIT_W-1:0]  flit;
    logic [NUM_REQ-1:0] rdy;
    logic [CNT_W-1:0]   pkt_cnt;

    assign on_ch = (c == 0) ? ~req_vc_sel : req_vc_sel;
    assign cand  = req_valid & req_is_header & on_ch & {NUM_REQ{ch_vcready[c]}};
    assign xfer  = vld & ch_ready[c];

    noc_rr_lock_arbiter #(
      .NUM_REQ (NUM_REQ),
      .CNT_W   (CNT_W),
      .IDX_W   (IDX_W)
    ) u_arb (
      .noc_clk_i   (noc_clk),
      .noc_rst_i   (noc_rst),
      .cand_i      (cand),
      .owner_ok_i  (on_ch),
      .xfer_i      (xfer),
      .xfer_tail_i (tail),
      .sel_vld_o   (sel_vld),
      .sel_idx_o   (sel_idx),
      .pkt_cnt_o   (pkt_cnt)
    );

    // Outputs are forced quiet while reset is asserted, whatever the requesters drive.
    always_comb begin
      vld  = 1'b0;
      hdr  = 1'b0;
      tail = 1'b0;
      flit = '0;
      rdy  = '0;
      if (!noc_rst && sel_vld) begin
        vld          = req_valid[sel_idx];
        hdr          = req_is_header[sel_idx];
        tail         = req_is_tail[sel_idx];
        flit         = req_flit[sel_idx*FLIT_W +: FLIT_W];
        rdy[sel_idx] = ch_ready[c];
      end
    end
  end

  assign req_ready          = g_ch[0].rdy | g_ch[1].rdy;

  assign ch0_send_valid     = g_ch[0].vld;
  assign ch0_send_flit      = g_ch[0].flit;
  assign ch0_send_is_header = g_ch[0].hdr;
  assign ch0_send_is_tail   = g_ch[0].tail;
  assign ch0_pkt_cnt        = g_ch[0].pkt_cnt;

  assign ch1_send_valid     = g_ch[1].vld;
  assign ch1_send_flit      = g_ch[1].flit;
  assign ch1_send_is_header = g_ch[1].hdr;
  assign ch1_send_is_tail   = g_ch[1].tail;
  assign ch1_pkt_cnt        = g_ch[1].pkt_cnt;

endmodule
